board_dp: RTL
=============

BOARD_DP -- requirements
Module: board_dp

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock port clka, reset port restart.
REQ-002 Ports, listed as name, direction, width, meaning:
- clka  in  1  clock; all state updates on negedge clka.
- restart  in  1  synchronous active-high reset.
- gen_rand_flag, set_board_flag, set_diff_flag, cell_flag, val_flag, check_flag  in  1 each  phase flags from controller.
- enter  in  1  user confirm.
- cell_in  in  7  cell index 0..80, row-major.
- digit_in  in  4  value 1..9.
- diff_in  in  2  difficulty.
- solved  out  1  board complete and correct.
- busy  out  1  init sweep running.
- write_ok, write_rej  out  1 each  one-cycle result pulses.
- cursor  out  7  selected cell.
- cell_val  out  4  grid value at cursor.
- cell_given  out  1  cursor cell is fixed.
- mismatch_cnt  out  7  cells differing from solution.

Function
REQ-003 The block SHALL decode flags by priority gen > board > diff > cell > val > check when more than one is high.
REQ-004 An 8-bit LFSR SHALL use taps x^8+x^6+x^5+x^4+1 and advance every cycle while gen_rand_flag=1 or busy=1.
REQ-005 On the first cycle of set_board_flag high (rising level), the block SHALL latch shift = lfsr mod 9.
REQ-006 Solution for cell i (r=i/9, c=i%9) SHALL be ((3*(r%3) + r/3 + c + shift) mod 9) + 1, computed combinationally.
REQ-007 When set_diff_flag=1, enter=1 and busy=0, the block SHALL latch diff_in, set busy=1 and start a sweep over idx 0..80, one cell per cycle.
REQ-008 Sweep cell i given rule: diff 0: lfsr<160; diff 1: lfsr<112; diff 2: lfsr<64; diff 3 (test): all cells except i=80.
- Given cells: grid=solution, given=1.
- Other cells: grid=0, given=0.
REQ-009 The sweep SHALL load mismatch_cnt with the count of non-given cells, clear busy after idx 80 (81 cycles total) and set board_ready.
REQ-010 When cell_flag=1 and enter=1, the block SHALL load cursor from cell_in if cell_in<81; otherwise cursor is unchanged.
REQ-011 When val_flag=1, enter=1 and busy=0, a write SHALL occur iff given[cursor]=0 and 1<=digit_in<=9. On a write:
- grid[cursor] <= digit_in; write_ok pulses one cycle.
- Otherwise write_rej pulses one cycle and grid is unchanged.
REQ-012 On a write, mismatch_cnt SHALL be updated as follows:
- Decrement when old!=sol and new==sol.
- Increment when old==sol and new!=sol.
- Otherwise unchanged.
- The range is 0..81 and the count never wraps.
REQ-013 solved SHALL be a register equal to board_ready && !busy && mismatch_cnt==0, valid by the cycle check_flag is first high.
REQ-014 Enter with cell_flag or val_flag while busy=1 SHALL be ignored: no pulse, no state change.
REQ-015 A set_diff enter while board_ready=1 SHALL restart the sweep and clear board_ready until it completes.
REQ-016 cell_val and cell_given SHALL reflect the cursor cell combinationally from registered storage.

Reset
REQ-017 restart=1 SHALL dominate all inputs and set:
- grid all 0, given all 0.
- cursor=0, shift=0, mismatch_cnt=0, busy=0, board_ready=0.
- solved=0, write_ok=0, write_rej=0.
- lfsr=8'hA5.
REQ-018 restart during a sweep SHALL abort it, and the next cycle SHALL show busy=0.

Structure
REQ-019 A shared package SHALL hold NUM_CELLS=81, LFSR_SEED=8'hA5, the difficulty thresholds and the difficulty encodings.
REQ-020 The solution formula SHALL be a sub-module sol_gen with inputs idx[6:0] and shift[3:0] and output digit[3:0]; board_dp instantiates it twice, once for the sweep index and once for the cursor.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: pulse restart, no gen_rand -> solved=0, busy=0, cursor=0, mismatch_cnt=0, lfsr=A5.
- Setup: set_board (shift=165 mod 9=3), then set_diff with diff_in=3 and enter -> busy high 81 cycles; then cell 0 = 4 given, cell 80 = 0 not given, mismatch_cnt=1.
- Solve: cell_flag with cell_in=80 and enter; val_flag with digit_in=2 and enter -> write_ok; mismatch_cnt=0; solved=1 at check_flag.
- Rejects: cursor=0 write 7 -> write_rej, cell_val stays 4; cursor=80 write 0 or 10 -> write_rej; cell_in=90 -> cursor unchanged.
- Count tracking: on cell 80, write 5 -> mismatch 1; write 2 -> 0; write 9 -> 1, solved=0.
- Abort: restart at sweep cycle 40 -> busy=0, grid cleared, solved=0; a val enter afterwards on cursor 0 -> write_ok (given cleared).

Source files
------------

// File: rtl/board_dp_pkg.sv
// Shared constants, encodings and small helpers for the sudoku board datapath.
package board_dp_pkg;
  localparam int         NUM_CELLS = 81;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // A cell is fixed when the LFSR sample falls below the threshold.
  localparam logic [7:0] THR_EASY = 8'd160;
  localparam logic [7:0] THR_MED  = 8'd112;
  localparam logic [7:0] THR_HARD = 8'd64;

  typedef enum logic [1:0] {
    DIFF_EASY = 2'd0,
    DIFF_MED  = 2'd1,
    DIFF_HARD = 2'd2,
    DIFF_TEST = 2'd3
  } diff_e;

  typedef enum logic [2:0] {
    OP_NONE, OP_GEN, OP_BOARD, OP_DIFF, OP_CELL, OP_VAL, OP_CHECK
  } op_e;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

  // x^8+x^6+x^5+x^4+1, shift-left Fibonacci form
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Only the highest-priority phase flag is acted on.
  function automatic op_e decode_op(input logic g, input logic b, input logic d,
                                    input logic c, input logic v, input logic k);
    if (g)      return OP_GEN;
    else if (b) return OP_BOARD;
    else if (d) return OP_DIFF;
    else if (c) return OP_CELL;
    else if (v) return OP_VAL;
    else if (k) return OP_CHECK;
    else        return OP_NONE;
  endfunction
endpackage

// File: rtl/board_dp_sol_gen.sv
// Solution digit for a cell: a shifted Latin-square pattern that is a valid sudoku.
module sol_gen (
  input  logic [6:0] idx,
  input  logic [3:0] shift,
  output logic [3:0] digit
);
  logic [6:0] w_r, w_c, w_s;

  assign w_r   = idx / 7'd9;
  assign w_c   = idx % 7'd9;
  assign w_s   = 7'd3 * (w_r % 7'd3) + w_r / 7'd3 + w_c + {3'd0, shift};
  assign digit = 4'((w_s % 7'd9) + 7'd1);
endmodule

// File: rtl/board_dp.sv
// Board datapath: LFSR, puzzle generation sweep, cursor, guarded writes, solve tracking.
module board_dp
  import board_dp_pkg::*;
(
  input  logic       clka,
  input  logic       restart,
  input  logic       gen_rand_flag,
  input  logic       set_board_flag,
  input  logic       set_diff_flag,
  input  logic       cell_flag,
  input  logic       val_flag,
  input  logic       check_flag,
  input  logic       enter,
  input  logic [6:0] cell_in,
  input  logic [3:0] digit_in,
  input  logic [1:0] diff_in,
  output logic       solved,
  output logic       busy,
  output logic       write_ok,
  output logic       write_rej,
  output logic [6:0] cursor,
  output logic [3:0] cell_val,
  output logic       cell_given,
  output logic [6:0] mismatch_cnt
);
  state_e r_state, w_state_nxt;
  op_e    w_op;

  logic [7:0]           r_lfsr;
  logic [3:0]           r_shift;
  logic [1:0]           r_diff;
  logic [6:0]           r_idx, r_cursor, r_mis;
  logic                 r_board_d, r_ready, r_solved, r_ok, r_rej;
  logic [3:0]           r_grid [NUM_CELLS];
  logic [NUM_CELLS-1:0] r_given;

  logic       w_busy, w_start, w_last, w_sweep_given, w_cell_sel, w_val_req, w_wr;
  logic [3:0] w_sol_sweep, w_sol_cur, w_old;

  assign w_op    = decode_op(gen_rand_flag, set_board_flag, set_diff_flag,
                             cell_flag, val_flag, check_flag);
  assign w_busy  = (r_state == ST_SWEEP);
  assign w_start = (w_op == OP_DIFF) && enter && !w_busy;
  assign w_last  = (r_idx == 7'(NUM_CELLS - 1));

  sol_gen u_sol_sweep (.idx(r_idx),    .shift(r_shift), .digit(w_sol_sweep));
  sol_gen u_sol_cur   (.idx(r_cursor), .shift(r_shift), .digit(w_sol_cur));

  // Fixed-cell decision for the cell currently being swept
  always_comb begin
    w_sweep_given = 1'b0;
    case (diff_e'(r_diff))
      DIFF_EASY: w_sweep_given = (r_lfsr < THR_EASY);
      DIFF_MED:  w_sweep_given = (r_lfsr < THR_MED);
      DIFF_HARD: w_sweep_given = (r_lfsr < THR_HARD);
      DIFF_TEST: w_sweep_given = (r_idx != 7'(NUM_CELLS - 1));
      default:   w_sweep_given = 1'b0;
    endcase
  end

  assign w_cell_sel = (w_op == OP_CELL) && enter && !w_busy && (cell_in < 7'(NUM_CELLS));
  assign w_val_req  = (w_op == OP_VAL) && enter && !w_busy;
  assign w_old      = r_grid[r_cursor];
  assign w_wr       = w_val_req && !r_given[r_cursor] &&
                      (digit_in != 4'd0) && (digit_in <= 4'd9);

  // Sweep FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_last)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep FSM state register
  always_ff @(negedge clka) begin
    if (restart) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // LFSR runs while the controller asks for randomness or a sweep consumes it
  always_ff @(negedge clka) begin
    if (restart)                         r_lfsr <= LFSR_SEED;
    else if (w_op == OP_GEN || w_busy)   r_lfsr <= lfsr_next(r_lfsr);
  end

  // Board storage, cursor, write handling and solve status
  always_ff @(negedge clka) begin
    if (restart) begin
      for (int i = 0; i < NUM_CELLS; i++) r_grid[i] <= 4'd0;
      r_given   <= '0;
      r_shift   <= 4'd0;
      r_diff    <= 2'd0;
      r_idx     <= 7'd0;
      r_cursor  <= 7'd0;
      r_mis     <= 7'd0;
      r_board_d <= 1'b0;
      r_ready   <= 1'b0;
      r_solved  <= 1'b0;
      r_ok      <= 1'b0;
      r_rej     <= 1'b0;
    end else begin
      r_ok      <= 1'b0;
      r_rej     <= 1'b0;
      r_board_d <= (w_op == OP_BOARD);
      if (w_op == OP_BOARD && !r_board_d) r_shift <= 4'(r_lfsr % 8'd9);

      if (w_start) begin
        r_diff  <= diff_in;
        r_idx   <= 7'd0;
        r_mis   <= 7'd0;
        r_ready <= 1'b0;
      end

      // Non-fixed cells start empty, so each one adds a mismatch
      if (w_busy) begin
        r_grid[r_idx]  <= w_sweep_given ? w_sol_sweep : 4'd0;
        r_given[r_idx] <= w_sweep_given;
        if (!w_sweep_given) r_mis <= r_mis + 7'd1;
        r_idx <= r_idx + 7'd1;
        if (w_last) r_ready <= 1'b1;
      end

      if (w_cell_sel) r_cursor <= cell_in;

      if (w_val_req) begin
        if (w_wr) begin
          r_grid[r_cursor] <= digit_in;
          r_ok <= 1'b1;
          if (w_old != w_sol_cur && digit_in == w_sol_cur && r_mis != 7'd0)
            r_mis <= r_mis - 7'd1;
          else if (w_old == w_sol_cur && digit_in != w_sol_cur && r_mis < 7'(NUM_CELLS))
            r_mis <= r_mis + 7'd1;
        end else begin
          r_rej <= 1'b1;
        end
      end

      r_solved <= r_ready && !w_busy && (r_mis == 7'd0);
    end
  end

  assign solved       = r_solved;
  assign busy         = w_busy;
  assign write_ok     = r_ok;
  assign write_rej    = r_rej;
  assign cursor       = r_cursor;
  assign cell_val     = r_grid[r_cursor];
  assign cell_given   = r_given[r_cursor];
  assign mismatch_cnt = r_mis;
endmodule
